// File: rtl/shift_issue_stage.sv
// Issue stage ahead of the combinational Shifter: decodes shift ops, resolves the shift amount,
// and holds Shifter-ready operands in a main register backed by a one-entry skid buffer.
module shift_issue_stage #(
  parameter int unsigned N   = 32,
  parameter int unsigned SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_rs1,
  input  logic [N-1:0]   in_rs2,
  input  logic [SHW-1:0] in_shamt,
  input  logic           in_is_imm,
  input  logic [2:0]     in_funct3,
  input  logic           in_funct7_5,
  input  logic [4:0]     in_rd,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_a,
  output logic [SHW-1:0] out_shamt,
  output logic [1:0]     out_type,
  output logic [4:0]     out_rd,
  output logic           out_illegal
);

  localparam logic [1:0] TypeSrl = 2'b00;
  localparam logic [1:0] TypeSll = 2'b01;
  localparam logic [1:0] TypeSra = 2'b10;
  localparam logic [1:0] TypeIll = 2'b11;

  typedef struct packed {
    logic [N-1:0]   a;
    logic [SHW-1:0] shamt;
    logic [1:0]     typ;
    logic [4:0]     rd;
    logic           illegal;
  } op_t;

  op_t  w_op;
  op_t  r_main, w_main_nxt;
  op_t  r_skid, w_skid_nxt;
  logic r_main_valid, w_main_valid_nxt;
  logic r_skid_valid, w_skid_valid_nxt;
  logic w_accept;
  logic w_main_free;

  // Only the low SHW bits of rs2 form a register-sourced shift amount.
  logic w_unused_rs2_hi;
  assign w_unused_rs2_hi = ^in_rs2[N-1:SHW];

  always_comb begin
    w_op.a       = in_rs1;
    w_op.shamt   = in_is_imm ? in_shamt : in_rs2[SHW-1:0];
    w_op.rd      = in_rd;
    w_op.typ     = TypeIll;
    w_op.illegal = 1'b1;
    if (in_funct3 == 3'b001 && !in_funct7_5) begin
      w_op.typ     = TypeSll;
      w_op.illegal = 1'b0;
    end else if (in_funct3 == 3'b101) begin
      w_op.typ     = in_funct7_5 ? TypeSra : TypeSrl;
      w_op.illegal = 1'b0;
    end
  end

  // A full skid deasserts in_ready, so it can never coincide with an accept.
  assign w_accept    = in_valid & ~r_skid_valid;
  assign w_main_free = ~r_main_valid | out_ready;

  always_comb begin
    w_main_nxt       = r_main;
    w_skid_nxt       = r_skid;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_valid_nxt = w_accept;
        if (w_accept) begin
          w_main_nxt = w_op;
        end
      end
    end else if (w_accept) begin
      w_skid_nxt       = w_op;
      w_skid_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main       <= w_main_nxt;
      r_skid       <= w_skid_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_a       = r_main.a;
  assign out_shamt   = r_main.shamt;
  assign out_type    = r_main.typ;
  assign out_rd      = r_main.rd;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_shamt;
  logic        in_is_imm;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_type;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        illegal;
  } op_t;

  op_t         model_q[$];
  logic [31:0] emitted[$];

  shift_issue_stage #(.N(32), .SHW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_shamt    (in_shamt),
    .in_is_imm   (in_is_imm),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_shamt   (out_shamt),
    .out_type    (out_type),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t ref_op(input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [4:0] shamt, input logic is_imm,
                                 input logic [2:0] f3, input logic f75, input logic [4:0] rd);
    op_t o;
    o.a     = rs1;
    o.shamt = is_imm ? shamt : rs2[4:0];
    o.rd    = rd;
    case ({f3, f75})
      4'b0010: o.typ = 2'b01;
      4'b1010: o.typ = 2'b00;
      4'b1011: o.typ = 2'b10;
      default: o.typ = 2'b11;
    endcase
    o.illegal = (o.typ == 2'b11);
    return o;
  endfunction

  // Reference: the stage is an in-order queue of at most two ops; in_ready means room for one more.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else begin
      bit acc, cons;
      acc  = in_valid && (model_q.size() < 2);
      cons = out_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (cons) void'(model_q.pop_front());
        if (acc) model_q.push_back(ref_op(in_rs1, in_rs2, in_shamt, in_is_imm, in_funct3,
                                          in_funct7_5, in_rd));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_a", 64'(out_a), 64'(0));
      check("rst_out_shamt", 64'(out_shamt), 64'(0));
      check("rst_out_type", 64'(out_type), 64'(0));
      check("rst_out_rd", 64'(out_rd), 64'(0));
      check("rst_out_illegal", 64'(out_illegal), 64'(0));
    end else begin
      check("mdl_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      check("mdl_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      if (model_q.size() > 0) begin
        check("mdl_out_a", 64'(out_a), 64'(model_q[0].a));
        check("mdl_out_shamt", 64'(out_shamt), 64'(model_q[0].shamt));
        check("mdl_out_type", 64'(out_type), 64'(model_q[0].typ));
        check("mdl_out_rd", 64'(out_rd), 64'(model_q[0].rd));
        check("mdl_out_illegal", 64'(out_illegal), 64'(model_q[0].illegal));
      end
      if (out_valid && out_ready && !flush) emitted.push_back(out_a);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] sh,
                        input logic imm, input logic [2:0] f3, input logic f75,
                        input logic [4:0] rd);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_shamt    = sh;
    in_is_imm   = imm;
    in_funct3   = f3;
    in_funct7_5 = f75;
    in_rd       = rd;
  endtask

  task automatic set_srl(input logic [31:0] a);
    set_op(a, 32'h3, 5'h0, 1'b0, 3'b101, 1'b0, a[4:0]);
  endtask

  initial begin
    op_t p;
    int  base;
    int  hits;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_shamt = '0; in_is_imm = 1'b0;
    in_funct3 = '0; in_funct7_5 = 1'b0; in_rd = '0;

    // Pin the model against hand-decoded encodings.
    p = ref_op(32'h8000_0000, 32'hFFFF_FFE4, 5'h1F, 1'b0, 3'b101, 1'b1, 5'd7);
    check("pin_sra_type", 64'(p.typ), 64'h2);
    check("pin_sra_shamt", 64'(p.shamt), 64'h4);
    p = ref_op(32'h1, 32'h0, 5'd31, 1'b1, 3'b001, 1'b0, 5'd1);
    check("pin_slli_shamt", 64'(p.shamt), 64'd31);
    p = ref_op(32'h1, 32'h0, 5'd3, 1'b1, 3'b001, 1'b1, 5'd1);
    check("pin_001_f7_illegal", 64'(p.illegal), 64'h1);

    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    check("post_rst_out_valid", 64'(out_valid), 64'h0);

    // Decode
    out_ready = 1'b1;
    set_op(32'h8000_0000, 32'hFFFF_FFE4, 5'h1F, 1'b0, 3'b101, 1'b1, 5'd7);
    step();
    check("dec_sra_valid", 64'(out_valid), 64'h1);
    check("dec_sra_type", 64'(out_type), 64'h2);
    check("dec_sra_shamt", 64'(out_shamt), 64'h4);
    check("dec_sra_a", 64'(out_a), 64'h8000_0000);
    check("dec_sra_rd", 64'(out_rd), 64'd7);
    set_op(32'h0000_0001, 32'h0000_0003, 5'd31, 1'b1, 3'b001, 1'b0, 5'd9);
    step();
    check("dec_slli_type", 64'(out_type), 64'h1);
    check("dec_slli_shamt", 64'(out_shamt), 64'd31);
    check("dec_slli_illegal", 64'(out_illegal), 64'h0);
    set_op(32'h1234_5678, 32'h0000_0002, 5'd0, 1'b0, 3'b000, 1'b0, 5'd3);
    step();
    check("dec_f3_000_type", 64'(out_type), 64'h3);
    check("dec_f3_000_illegal", 64'(out_illegal), 64'h1);
    in_valid = 1'b0;
    step();
    check("dec_drain", 64'(out_valid), 64'h0);

    // Backpressure: A main, B skid, C waits in decode
    out_ready = 1'b0;
    set_srl(32'hA000_000A);
    step();
    check("bp_a_main", 64'(out_a), 64'hA000_000A);
    check("bp_ready_a", 64'(in_ready), 64'h1);
    set_srl(32'hB000_000B);
    step();
    check("bp_a_held", 64'(out_a), 64'hA000_000A);
    check("bp_skid_full", 64'(in_ready), 64'h0);
    set_srl(32'hC000_000C);
    step();
    check("bp_a_still", 64'(out_a), 64'hA000_000A);
    check("bp_c_blocked", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    step();
    check("bp_b_out", 64'(out_a), 64'hB000_000B);
    check("bp_ready_again", 64'(in_ready), 64'h1);
    step();
    check("bp_c_out", 64'(out_a), 64'hC000_000C);
    check("bp_c_valid", 64'(out_valid), 64'h1);
    in_valid = 1'b0;
    step();
    check("bp_drained", 64'(out_valid), 64'h0);

    // Throughput: 16 ops back-to-back, latency 1
    base = emitted.size();
    for (int i = 0; i < 16; i++) begin
      set_srl(32'h5500_0000 + 32'(i));
      step();
      check("tp_valid", 64'(out_valid), 64'h1);
      check("tp_a", 64'(out_a), 64'(32'h5500_0000 + 32'(i)));
    end
    in_valid = 1'b0;
    step();
    check("tp_count", 64'(emitted.size() - base), 64'd16);
    check("tp_idle", 64'(out_valid), 64'h0);

    // Flush with skid full plus a same-cycle incoming op and consume
    out_ready = 1'b0;
    set_srl(32'hF1F1_0001);
    step();
    set_srl(32'hF1F1_0002);
    step();
    check("fl_skid_full", 64'(in_ready), 64'h0);
    set_srl(32'hF1F1_0003);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'h0);
    check("fl_in_ready", 64'(in_ready), 64'h1);
    repeat (3) step();
    check("fl_stays_empty", 64'(out_valid), 64'h0);
    hits = 0;
    foreach (emitted[i]) if (emitted[i][31:16] == 16'hF1F1) hits++;
    check("fl_never_emitted", 64'(hits), 64'h0);

    // Reset mid-stream with two ops held
    out_ready = 1'b0;
    set_srl(32'h7700_0001);
    step();
    set_srl(32'h7700_0002);
    step();
    in_valid = 1'b0;
    check("mr_held", 64'(out_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_async_valid", 64'(out_valid), 64'h0);
    check("mr_async_a", 64'(out_a), 64'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("mr_in_ready", 64'(in_ready), 64'h1);
    check("mr_out_valid", 64'(out_valid), 64'h0);

    // Random stress against the model
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                        : (($urandom_range(0, 1) == 1) ? 3'b001 : 3'b101);
      set_op($urandom, $urandom, 5'($urandom), 1'($urandom), f3, 1'($urandom), 5'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("end_drained", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
